// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the adder, the result stage and its consumer.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output in_valid, A, B, Sum, Cout, out_ready,
    input  in_ready, out_valid, Result, C, Z, N, V
  );

  modport slave (
    input  in_valid, A, B, Sum, Cout, out_ready,
    output in_ready, out_valid, Result, C, Z, N, V
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage after the adder: derives C/Z/N/V, buffers results in a
// small FIFO and keeps the chaining carry for add-with-carry.
module alu_result_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_stage_if.slave      bus,
  output logic                   carry_q,
  input  logic                   carry_clr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = WIDTH + 4;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef logic [EW-1:0] entry_t;

  entry_t        mem [DEPTH];
  entry_t        din;
  entry_t        head_q;
  entry_t        head_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          flag_v;

  assign bus.in_ready  = (count != FULL_CNT);
  assign bus.out_valid = (count != '0);
  assign {bus.Result, bus.C, bus.Z, bus.N, bus.V} = head_q;

  always_comb begin
    flag_v     = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (bus.Sum[WIDTH-1] != bus.A[WIDTH-1]);
    din        = {bus.Sum, bus.Cout, (bus.Sum == '0), bus.Sum[WIDTH-1], flag_v};
    push       = bus.in_valid && bus.in_ready;
    pop        = bus.out_valid && bus.out_ready;
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
    // The entry becoming head may be the one written on this same edge
    // (push into empty, or push+pop with a single entry); forward it from din.
    head_next = (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      // Head register only reloads while something is buffered, so an empty
      // stage keeps presenting the last popped entry.
      if (count_next != '0) begin
        head_q <= head_next;
      end
      if (push) begin
        carry_q <= bus.Cout;
      end else if (carry_clr) begin
        carry_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 8-bit adder.
- Captures the adder's Sum/Cout together with the operands actually applied, and derives the status flags C, Z, N and V.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Holds a carry register that feeds Cin of the adder for add-with-carry chaining.

Parameters:
- WIDTH, 8: datapath width of A, B and Sum.
- DEPTH, 2: number of result entries buffered; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a valid adder result this cycle.
- in_ready  output  1  stage can accept a result.
- A  input  WIDTH  first operand applied to the adder.
- B  input  WIDTH  second operand as applied to the adder (already inverted for subtract).
- Sum  input  WIDTH  adder sum.
- Cout  input  1  adder carry-out.
- out_valid  output  1  Result/flags at FIFO head are valid.
- out_ready  input  1  downstream accepts head entry.
- Result  output  WIDTH  head-entry sum.
- C  output  1  head-entry carry flag.
- Z  output  1  head-entry zero flag.
- N  output  1  head-entry negative flag.
- V  output  1  head-entry signed-overflow flag.
- carry_q  output  1  carry of the most recently accepted result; drives adder Cin for chained ops.
- carry_clr  input  1  synchronous clear of carry_q.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst_n low, asynchronous): the FIFO is emptied.
  - count=0, out_valid=0, in_ready=1, Result=0, C=Z=N=V=0, carry_q=0.
  - Read and write pointers return to 0.
  - Reset asserted mid-transfer discards all buffered entries; nothing is retained.
- Flag derivation is combinational from the inputs and stored on push:
  - C=Cout.
  - Z=(Sum==0).
  - N=Sum[WIDTH-1].
  - V=(A[WIDTH-1]==B[WIDTH-1]) && (Sum[WIDTH-1]!=A[WIDTH-1]).
- Push: in_valid && in_ready at a rising edge writes {Sum,C,Z,N,V} at the write pointer and increments the pointer, wrapping modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge advances the read pointer, wrapping modulo DEPTH.
- in_ready = (count != DEPTH). It depends on registered state only, never on out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- Result/C/Z/N/V are driven from the head entry. They hold stable while out_valid && !out_ready.
  - When empty they show the last popped entry. At reset they show 0.
- Latency: a push into an empty stage at edge k gives out_valid=1 and the head data immediately after edge k, i.e. one cycle. There is no bypass in the same cycle.
- Count update on each edge:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (only possible when 0<count<DEPTH): count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0 and upstream must hold its data. A pop in this cycle does not enable a push in the same cycle; in_ready rises the cycle after.
- Empty: a pop is impossible because out_valid=0. out_ready is ignored.
- Ordering is strictly first-in first-out.
- carry_q, updated on each edge in priority order:
  - A push loads Cout.
  - Otherwise carry_clr loads 0.
  - Otherwise it holds.
  - A push in the same cycle as carry_clr: the push wins and carry_q=Cout.
- Results are never dropped and never duplicated.

Test Plan:
- Reset, then out_ready=1 and push A=0x0F, B=0x01, Sum=0x10, Cout=0 -> one cycle later out_valid=1, Result=0x10, C=0, Z=0, N=0, V=0, carry_q=0; out_valid=0 on the following cycle.
- Push A=0xFF, B=0x01, Sum=0x00, Cout=1 -> Result=0x00, C=1, Z=1, N=0, V=0, carry_q=1. Next cycle carry_clr=1 with no push -> carry_q=0.
- Push A=0x7F, B=0x01, Sum=0x80, Cout=0 -> Result=0x80, N=1, V=1, C=0, Z=0. Push A=0x80, B=0xFF, Sum=0x7F, Cout=1 -> V=1, C=1, N=0.
- Backpressure: out_ready=0, offer 0x11, 0x22, 0x33 on consecutive cycles -> 0x11 and 0x22 accepted, in_ready=0 and count=2, 0x33 held. Raise out_ready -> outputs 0x11, then 0x22, then 0x33 in order, no loss.
- With count=1, push and pop in the same cycle -> count stays 1, head advances to the new entry, carry_q takes the new Cout. Push together with carry_clr=1 and Cout=1 -> carry_q=1.
- Fill to count=2, then assert rst_n=0 between clock edges -> out_valid=0, in_ready=1, count=0, carry_q=0 immediately. After release, the first push appears as the sole head entry.
